// File: rtl/mem_port_arbiter.sv
// =============================================================================
// mem_port_arbiter
// -----------------------------------------------------------------------------
// Shares one single-ported 64-bit memory between the core's instruction-fetch
// port and its data (load/store) port. The core can then run from one unified
// memory instead of separate instruction and data memories.
//
// Data requests normally win. A streak counter limits how many data grants in
// a row may be given while fetch is waiting, so fetch always makes progress.
//
// Each access goes through three states:
//   IDLE -> arbitrate and latch the winner onto the memory-side registers
//   MEM  -> hold m_req/m_we/m_addr/m_wdata until m_ready, capture read data
//   ACK  -> one-cycle ack pulse to the owner; requests are not looked at
//
// Optional build macro:
//   MEM_ARB_STATS_EN  adds the saturating counters stat_fetch, stat_data and
//                     stat_wait. If the macro is undefined, those ports and
//                     counters do not exist.
//
// Parameters:
//   ADDR_BITS     memory word-address width (requesters and memory side)
//   MAX_D_STREAK  data grants allowed in a row while fetch waits (>= 1)
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   i_req/i_addr       fetch request (held until i_ack) and word address
//   i_rdata/i_ack      fetched instruction (low 32 bits), completion pulse
//   d_req/d_we         data request (held until d_ack), 1 = store
//   d_addr/d_wdata     data address and store data
//   d_rdata/d_ack      load data, completion pulse
//   m_req/m_we         memory request (held until m_ready), write enable
//   m_addr/m_wdata     memory address and write data
//   m_rdata/m_ready    memory read data, access-complete strobe
//   stat_*             (MEM_ARB_STATS_EN only) usage counters
// =============================================================================
module mem_port_arbiter #(
    parameter int ADDR_BITS    = 6,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    // instruction-fetch port
    input  logic                 i_req,
    input  logic [ADDR_BITS-1:0] i_addr,
    output logic [31:0]          i_rdata,
    output logic                 i_ack,
    // data port
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [63:0]          d_wdata,
    output logic [63:0]          d_rdata,
    output logic                 d_ack,
    // memory side
    output logic                 m_req,
    output logic                 m_we,
    output logic [ADDR_BITS-1:0] m_addr,
    output logic [63:0]          m_wdata,
    input  logic [63:0]          m_rdata,
    input  logic                 m_ready
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]          stat_fetch,
    output logic [31:0]          stat_data,
    output logic [31:0]          stat_wait
`endif
);

    // The streak counter must be able to hold MAX_D_STREAK itself.
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                state_r;
    logic                  owner_d_r;      // 1 = the access in flight belongs to the data port
    logic [STREAK_W-1:0]   streak_r;       // data grants in a row while fetch was waiting

    logic                  streak_at_max_s;
    logic                  grant_d_s;
    logic                  grant_i_s;
    logic [STREAK_W-1:0]   streak_next_s;

    // Arbitration: data wins unless fetch is also waiting and the streak is used up
    always_comb begin
        streak_at_max_s = (streak_r == STREAK_MAX);
        grant_d_s       = 1'b0;
        grant_i_s       = 1'b0;
        if (d_req && !(i_req && streak_at_max_s)) begin
            grant_d_s = 1'b1;
        end else if (i_req) begin
            grant_i_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Streak update: a data grant only counts against fetch if fetch was waiting
    always_comb begin
        streak_next_s = streak_r;
        if (grant_d_s) begin
            if (i_req) begin
                if (streak_at_max_s) begin
                    streak_next_s = STREAK_MAX;
                end else begin
                    streak_next_s = streak_r + STREAK_W'(1);
                end
            end else begin
                streak_next_s = {STREAK_W{1'b0}};
            end
        end else if (grant_i_s) begin
            streak_next_s = {STREAK_W{1'b0}};
        end else begin
            streak_next_s = streak_r;
        end
    end

    // Access sequencer: latches the winner, drives the memory, pulses the ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            owner_d_r <= 1'b0;
            streak_r  <= {STREAK_W{1'b0}};
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= {ADDR_BITS{1'b0}};
            m_wdata   <= 64'h0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= 32'h0;
            d_rdata   <= 64'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (grant_d_s || grant_i_s) begin
                        // The memory-side registers double as the request latch.
                        state_r   <= ST_MEM;
                        owner_d_r <= grant_d_s;
                        streak_r  <= streak_next_s;
                        m_req     <= 1'b1;
                        m_we      <= grant_d_s ? d_we : 1'b0;
                        m_addr    <= grant_d_s ? d_addr : i_addr;
                        m_wdata   <= grant_d_s ? d_wdata : 64'h0;
                    end
                end
                ST_MEM: begin
                    if (m_ready) begin
                        state_r <= ST_ACK;
                        m_req   <= 1'b0;
                        // Drop the write enable with the request so a store
                        // never appears to be pending outside MEM.
                        m_we    <= 1'b0;
                        if (owner_d_r) begin
                            d_ack <= 1'b1;
                            // A store leaves the last load data untouched.
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_rdata[31:0];
                        end
                    end
                end
                ST_ACK: begin
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    m_req   <= 1'b0;
                    m_we    <= 1'b0;
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

    // Usage counters: completions per owner, and request-pending cycles with no ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fetch <= 32'h0;
            stat_data  <= 32'h0;
            stat_wait  <= 32'h0;
        end else begin
            if ((state_r == ST_MEM) && m_ready) begin
                if (owner_d_r) begin
                    stat_data <= sat_inc(stat_data);
                end else begin
                    stat_fetch <= sat_inc(stat_fetch);
                end
            end
            if ((i_req || d_req) && !i_ack && !d_ack) begin
                stat_wait <= sat_inc(stat_wait);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// =============================================================================
// tb_mem_port_arbiter
// Drives both requester ports and plays the memory. A transaction-level model
// predicts acks, read data, memory-side outputs and (if built with
// MEM_ARB_STATS_EN) the statistics counters. One compare process checks the
// DUT against the model on every falling edge. Directed scenarios add literal
// expectations that pin the model.
// =============================================================================
module tb_mem_port_arbiter;
    localparam int ADDR_BITS    = 6;
    localparam int MAX_D_STREAK = 4;
    localparam int DEPTH        = 1 << ADDR_BITS;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_req = 1'b0;
    logic [ADDR_BITS-1:0] i_addr = '0;
    logic [31:0]          i_rdata;
    logic                 i_ack;
    logic                 d_req = 1'b0;
    logic                 d_we = 1'b0;
    logic [ADDR_BITS-1:0] d_addr = '0;
    logic [63:0]          d_wdata = '0;
    logic [63:0]          d_rdata;
    logic                 d_ack;
    logic                 m_req;
    logic                 m_we;
    logic [ADDR_BITS-1:0] m_addr;
    logic [63:0]          m_wdata;
    logic [63:0]          m_rdata = '0;
    logic                 m_ready = 1'b0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]          stat_fetch;
    logic [31:0]          stat_data;
    logic [31:0]          stat_wait;
`endif

    mem_port_arbiter #(.ADDR_BITS(ADDR_BITS), .MAX_D_STREAK(MAX_D_STREAK)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready)
`ifdef MEM_ARB_STATS_EN
        , .stat_fetch(stat_fetch), .stat_data(stat_data), .stat_wait(stat_wait)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model (one transaction at a time) ----------
    logic [63:0]          mem [0:DEPTH-1];
    bit                   mdl_busy = 1'b0;   // a transaction has been granted
    bit                   mdl_done = 1'b0;   // memory finished it; ack is showing
    bit                   mdl_own_d = 1'b0;
    bit                   mdl_we = 1'b0;
    logic [ADDR_BITS-1:0] mdl_addr = '0;
    logic [63:0]          mdl_wdata = '0;
    int                   mdl_run = 0;       // data wins in a row while fetch waited
    logic [31:0]          mdl_i_rdata = '0;
    logic [63:0]          mdl_d_rdata = '0;
    longint               mdl_n_fetch = 0, mdl_n_data = 0, mdl_n_wait = 0;

    task automatic model_step();
        if (rst) begin
            mdl_busy = 1'b0; mdl_done = 1'b0; mdl_run = 0;
            mdl_i_rdata = '0; mdl_d_rdata = '0;
            mdl_n_fetch = 0; mdl_n_data = 0; mdl_n_wait = 0;
        end else begin
            if ((i_req || d_req) && !(mdl_busy && mdl_done)) mdl_n_wait++;
            if (!mdl_busy) begin
                if (i_req || d_req) begin
                    mdl_busy = 1'b1;
                    mdl_done = 1'b0;
                    if (i_req && (!d_req || mdl_run == MAX_D_STREAK)) begin
                        mdl_own_d = 1'b0; mdl_we = 1'b0; mdl_addr = i_addr; mdl_run = 0;
                    end else begin
                        mdl_own_d = 1'b1; mdl_we = d_we; mdl_addr = d_addr; mdl_wdata = d_wdata;
                        if (!i_req) mdl_run = 0;
                        else if (mdl_run < MAX_D_STREAK) mdl_run++;
                    end
                end
            end else if (!mdl_done) begin
                if (m_ready) begin
                    mdl_done = 1'b1;
                    if (mdl_own_d) begin
                        mdl_n_data++;
                        if (mdl_we) mem[mdl_addr] = mdl_wdata;
                        else mdl_d_rdata = mem[mdl_addr];
                    end else begin
                        mdl_n_fetch++;
                        mdl_i_rdata = mem[mdl_addr][31:0];
                    end
                end
            end else begin
                mdl_busy = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    function automatic logic [63:0] sat32(input longint v);
        return (v > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : 64'(v);
    endfunction

    // ---------------- compare process ---------------------------------------
    always @(negedge clk) begin
        check("i_ack",   64'(i_ack),   64'(mdl_busy && mdl_done && !mdl_own_d));
        check("d_ack",   64'(d_ack),   64'(mdl_busy && mdl_done && mdl_own_d));
        check("m_req",   64'(m_req),   64'(mdl_busy && !mdl_done));
        check("i_rdata", 64'(i_rdata), 64'(mdl_i_rdata));
        check("d_rdata", d_rdata,      mdl_d_rdata);
        if (mdl_busy && !mdl_done) begin
            check("m_addr", 64'(m_addr), 64'(mdl_addr));
            check("m_we",   64'(m_we),   64'(mdl_we));
            if (mdl_we) check("m_wdata", m_wdata, mdl_wdata);
        end
`ifdef MEM_ARB_STATS_EN
        check("stat_fetch", 64'(stat_fetch), sat32(mdl_n_fetch));
        check("stat_data",  64'(stat_data),  sat32(mdl_n_data));
        check("stat_wait",  64'(stat_wait),  sat32(mdl_n_wait));
`endif
    end

    // ---------------- requesters and memory responder -----------------------
    bit                   rand_mode = 1'b0;
    int                   pend_i = 0, pend_d = 0;
    logic [ADDR_BITS-1:0] next_i_addr = '0, next_d_addr = '0;
    bit                   next_d_we = 1'b0;
    logic [63:0]          next_d_wdata = '0;
    int                   mem_wait = 0, mem_delay = 0, fixed_delay = 0;
    int                   ack_log[$];      // 1 = data ack, 2 = fetch ack
    int                   both_ack = 0;
    int                   i_start = 0, d_start = 0, last_i_lat = 0, last_d_lat = 0;
    int                   mreq_run = 0, last_mreq_run = 0;
    logic [ADDR_BITS-1:0] last_m_addr = '0;
    bit                   last_m_we = 1'b0;
    logic [63:0]          last_m_wdata = '0;

    task automatic set_delay(input int d);
        fixed_delay = d;
        mem_delay   = d;
    endtask

    task automatic bus_cycle();
        if (i_ack && d_ack) both_ack++;
        if (m_req) begin
            last_m_addr = m_addr; last_m_we = m_we; last_m_wdata = m_wdata;
            mreq_run++;
            if (mem_wait >= mem_delay) begin
                m_ready = 1'b1;
                m_rdata = mem[m_addr];
                mem_wait = 0;
                mem_delay = rand_mode ? int'($urandom_range(0, 3)) : fixed_delay;
            end else begin
                m_ready = 1'b0;
                m_rdata = {$urandom, $urandom};
                mem_wait++;
            end
        end else begin
            if (mreq_run > 0) begin
                last_mreq_run = mreq_run;
                mreq_run = 0;
            end
            m_ready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            m_rdata  = {$urandom, $urandom};
            mem_wait = 0;
        end
        if (i_ack) begin
            i_req = 1'b0;
            ack_log.push_back(2);
            last_i_lat = cyc - i_start + 1;
        end else if (!i_req && pend_i > 0) begin
            i_req  = 1'b1;
            i_addr = rand_mode ? ADDR_BITS'($urandom) : next_i_addr;
            i_start = cyc;
            pend_i--;
        end
        if (d_ack) begin
            d_req = 1'b0;
            ack_log.push_back(1);
            last_d_lat = cyc - d_start + 1;
        end else if (!d_req && pend_d > 0) begin
            d_req = 1'b1;
            if (rand_mode) begin
                d_we = 1'($urandom_range(0, 1)); d_addr = ADDR_BITS'($urandom);
                d_wdata = {$urandom, $urandom};
            end else begin
                d_we = next_d_we; d_addr = next_d_addr; d_wdata = next_d_wdata;
            end
            d_start = cyc;
            pend_d--;
        end
        if (rand_mode) begin
            if (pend_i == 0 && $urandom_range(0, 3) == 0) pend_i = 1;
            if (pend_d == 0 && $urandom_range(0, 2) == 0) pend_d = int'($urandom_range(1, 6));
        end
    endtask

    task automatic run_acks(input int n, input int limit, input string name);
        int k;
        k = 0;
        while (ack_log.size() < n && k < limit) begin
            @(negedge clk);
            bus_cycle();
            k++;
        end
        check({name, " completes"}, 64'(ack_log.size() >= n), 64'd1);
    endtask

    task automatic one_access(input bit is_d, input bit we, input logic [ADDR_BITS-1:0] addr,
                              input logic [63:0] wdata, input string name);
        ack_log.delete();
        if (is_d) begin
            next_d_we = we; next_d_addr = addr; next_d_wdata = wdata; pend_d = 1;
        end else begin
            next_i_addr = addr; pend_i = 1;
        end
        run_acks(1, 40, name);
    endtask

    function automatic int log_at(input int idx);
        return (idx < ack_log.size()) ? ack_log[idx] : -1;
    endfunction

    // ---------------- main sequence -----------------------------------------
    initial begin
        int k;
        logic [5:0] seq;
        for (int a = 0; a < DEPTH; a++) mem[a] = {$urandom, $urandom};

        // reset values
        @(negedge clk);
        bus_cycle();
        check("rst i_rdata", 64'(i_rdata), 64'h0);
        check("rst d_rdata", d_rdata, 64'h0);
        check("rst acks", 64'({i_ack, d_ack}), 64'h0);
        check("rst m_side", 64'({m_req, m_we, m_addr}), 64'h0);
        check("rst m_wdata", m_wdata, 64'h0);
        @(negedge clk);
        bus_cycle();
        rst = 1'b0;

        // single fetch, memory ready in the same cycle as m_req
        mem[5] = 64'h0000_0000_0020_0093;
        set_delay(0);
        one_access(1'b0, 1'b0, 6'd5, 64'h0, "fetch5");
        check("fetch5 owner", 64'(log_at(0)), 64'd2);
        check("fetch5 latency", 64'(last_i_lat), 64'd3);
        check("fetch5 m_addr", 64'(last_m_addr), 64'd5);
        check("fetch5 m_we", 64'(last_m_we), 64'd0);
        check("fetch5 i_rdata", 64'(i_rdata), 64'h0000_0000_0020_0093);

        // store with four wait states
        set_delay(4);
        one_access(1'b1, 1'b1, 6'd9, 64'hDEAD_BEEF_0123_4567, "store9");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus_cycle();
        end
        check("store9 single ack", 64'(ack_log.size()), 64'd1);
        check("store9 m_req cycles", 64'(last_mreq_run), 64'd5);
        check("store9 m_we", 64'(last_m_we), 64'd1);
        check("store9 m_wdata", last_m_wdata, 64'hDEAD_BEEF_0123_4567);
        check("store9 d_rdata kept", d_rdata, 64'h0);

        // load the stored word back
        set_delay(0);
        one_access(1'b1, 1'b0, 6'd9, 64'h0, "load9");
        check("load9 d_rdata", d_rdata, 64'hDEAD_BEEF_0123_4567);
        check("load9 latency", 64'(last_d_lat), 64'd3);

        // simultaneous requests: data first, then fetch
        ack_log.delete();
        next_i_addr = 6'd12; next_d_addr = 6'd13; next_d_we = 1'b0;
        pend_i = 1; pend_d = 1;
        run_acks(2, 40, "both");
        check("both first", 64'(log_at(0)), 64'd1);
        check("both second", 64'(log_at(1)), 64'd2);

        // data back-to-back with fetch waiting: D,D,D,D,I,D
        ack_log.delete();
        next_d_addr = 6'd20; next_i_addr = 6'd21;
        pend_d = 5; pend_i = 1;
        run_acks(6, 200, "streak");
        seq = '0;
        for (int s = 0; s < 6; s++) seq = {seq[4:0], log_at(s) == 1};
        check("streak order", 64'(seq), 64'(6'b111101));
        check("never both acks", 64'(both_ack), 64'd0);

        // reset in the middle of an access, then a fresh fetch
        ack_log.delete();
        mem[7] = 64'h1111_2222_3333_4444;
        set_delay(1000);
        next_i_addr = 6'd7;
        pend_i = 1;
        k = 0;
        while (!m_req && k < 20) begin
            @(negedge clk);
            bus_cycle();
            k++;
        end
        check("pre-reset m_req", 64'(m_req), 64'd1);
        @(negedge clk);
        bus_cycle();
        #2 rst = 1'b1;
        #1;
        check("async rst m_req", 64'(m_req), 64'd0);
        check("async rst acks", 64'({i_ack, d_ack}), 64'd0);
        set_delay(0);
        @(negedge clk);
        bus_cycle();
        @(negedge clk);
        bus_cycle();
        rst = 1'b0;
        run_acks(1, 40, "post-reset fetch");
        check("post-reset owner", 64'(log_at(0)), 64'd2);
        check("post-reset i_rdata", 64'(i_rdata), 64'h0000_0000_3333_4444);

        // two more fetches and two loads: 3 fetches, 2 loads since reset
        one_access(1'b0, 1'b0, 6'd1, 64'h0, "stat fetch a");
        one_access(1'b0, 1'b0, 6'd2, 64'h0, "stat fetch b");
        one_access(1'b1, 1'b0, 6'd3, 64'h0, "stat load a");
        one_access(1'b1, 1'b0, 6'd4, 64'h0, "stat load b");
`ifdef MEM_ARB_STATS_EN
        check("stat_fetch literal", 64'(stat_fetch), 64'd3);
        check("stat_data literal", 64'(stat_data), 64'd2);
        check("stat_wait literal", 64'(stat_wait), 64'd10);
`endif

        // randomized traffic, random wait states, stray m_ready outside MEM
        rand_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            bus_cycle();
        end
        rand_mode = 1'b0;
        pend_i = 0;
        pend_d = 0;
        k = 0;
        while ((i_req || d_req || m_req || i_ack || d_ack) && k < 500) begin
            @(negedge clk);
            bus_cycle();
            k++;
        end
        check("drain", 64'(i_req || d_req || m_req), 64'd0);
        check("random never both acks", 64'(both_ack), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
